// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the 4-source round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {StIdle, StBusy} arb_state_e;

   localparam int unsigned DefW       = 4;
   localparam int unsigned DefMaxHold = 4;

   typedef logic [1:0] src_idx_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of req_i searching from start_i upward mod 4.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [3:0] req_i,
   input  logic [1:0] start_i,
   output logic       found_o,
   output logic [1:0] idx_o
);

   src_idx_t cand;

   // Walk the search order backwards so the earliest candidate is the last one written.
   always_comb begin
      found_o = 1'b0;
      idx_o   = start_i;
      cand    = start_i;
      for (int k = 3; k >= 0; k--) begin
         cand = start_i + src_idx_t'(k);
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter over four sources with a hold limit, driving a registered 4:1 data mux.
module mux4_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned W        = DefW,
   parameter int unsigned MAX_HOLD = DefMaxHold
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic [3:0]   req_i,
   input  logic [W-1:0] x0_i,
   input  logic [W-1:0] x1_i,
   input  logic [W-1:0] x2_i,
   input  logic [W-1:0] x3_i,
   output logic [3:0]   gnt_o,
   output logic [1:0]   s_o,
   output logic [W-1:0] y_o,
   output logic         y_valid_o
);

   localparam logic [3:0] HoldMax = 4'(MAX_HOLD - 1);

   arb_state_e   state_q;
   logic [3:0]   gnt_q;
   src_idx_t     s_q;
   src_idx_t     ptr_q;
   logic [3:0]   hold_q;
   logic [W-1:0] y_q;
   logic         y_valid_q;

   logic [3:0]   others;
   logic         owner_req;
   logic [3:0]   pick_mask;
   src_idx_t     pick_start;
   logic         pick_found;
   logic [1:0]   pick_idx;
   logic [W-1:0] x_sel;

   assign others    = req_i & ~gnt_q;
   assign owner_req = |(req_i & gnt_q);

   // While busy, the owner only competes again when it is the sole requester.
   always_comb begin
      pick_mask  = req_i;
      pick_start = ptr_q;
      if (state_q == StBusy) begin
         pick_mask  = (others != 4'b0) ? others : req_i;
         pick_start = s_q + 2'd1;
      end
   end

   rr_pick4 u_pick (
      .req_i   (pick_mask),
      .start_i (pick_start),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      unique case (s_q)
         2'd0:    x_sel = x0_i;
         2'd1:    x_sel = x1_i;
         2'd2:    x_sel = x2_i;
         default: x_sel = x3_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         gnt_q     <= 4'b0;
         s_q       <= 2'd0;
         ptr_q     <= 2'd0;
         hold_q    <= 4'd0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else begin
         if (gnt_q != 4'b0) begin
            y_q       <= x_sel;
            y_valid_q <= 1'b1;
         end else begin
            y_valid_q <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               if (pick_found) begin
                  state_q <= StBusy;
                  gnt_q   <= 4'b0001 << pick_idx;
                  s_q     <= pick_idx;
                  hold_q  <= 4'd0;
                  ptr_q   <= pick_idx + 2'd1;
               end
            end
            StBusy: begin
               if (req_i == 4'b0) begin
                  state_q <= StIdle;
                  gnt_q   <= 4'b0;
               end else if (owner_req && (hold_q < HoldMax || others == 4'b0)) begin
                  if (hold_q < HoldMax) begin
                     hold_q <= hold_q + 4'd1;
                  end
               end else begin
                  gnt_q  <= 4'b0001 << pick_idx;
                  s_q    <= pick_idx;
                  hold_q <= 4'd0;
                  ptr_q  <= pick_idx + 2'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gnt_o     = gnt_q;
   assign s_o       = s_q;
   assign y_o       = y_q;
   assign y_valid_o = y_valid_q;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mux4_arbiter;

   localparam int MAXH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0;
   logic [3:0] x0 = 4'h0, x1 = 4'h0, x2 = 4'h0, x3 = 4'h0;
   logic [3:0] gnt;
   logic [1:0] s;
   logic [3:0] y;
   logic       y_valid;

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 when idle), rotation pointer, hold count, output image.
   int         m_owner, m_ptr, m_hold, m_s;
   logic [3:0] m_y;
   logic       m_yv;

   mux4_arbiter #(.W(4), .MAX_HOLD(MAXH)) dut (
      .clk_i     (clk),
      .rst_n     (rst_n),
      .req_i     (req),
      .x0_i      (x0),
      .x1_i      (x1),
      .x2_i      (x2),
      .x3_i      (x3),
      .gnt_o     (gnt),
      .s_o       (s),
      .y_o       (y),
      .y_valid_o (y_valid)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_owner = -1; m_ptr = 0; m_hold = 0; m_s = 0; m_y = 4'h0; m_yv = 1'b0;
   endfunction

   function automatic int search(input logic [3:0] m, input int from);
      for (int k = 0; k < 4; k++) if (m[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   function automatic void grant(input int w);
      m_owner = w; m_s = w; m_hold = 0; m_ptr = (w + 1) % 4;
   endfunction

   function automatic void model_step(input logic [3:0] r, input logic [15:0] xv);
      logic [3:0] oth;
      if (m_owner >= 0) begin m_y = xv[4*m_s +: 4]; m_yv = 1'b1; end
      else m_yv = 1'b0;
      if (r == 4'b0) m_owner = -1;
      else if (m_owner < 0) grant(search(r, m_ptr));
      else begin
         oth = r & ~(4'b0001 << m_owner);
         if (r[m_owner] && (m_hold < MAXH - 1 || oth == 4'b0)) begin
            if (m_hold < MAXH - 1) m_hold++;
         end else grant(search((oth != 4'b0) ? oth : r, m_owner + 1));
      end
   endfunction

   function automatic logic [3:0] exp_gnt();
      return (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
   endfunction

   // Drive one cycle of inputs (after the previous edge), advance the model at the edge, sample #1 later.
   task automatic drive_cycle(input logic [3:0] r, input logic [15:0] xv);
      req = r; x0 = xv[3:0]; x1 = xv[7:4]; x2 = xv[11:8]; x3 = xv[15:12];
      @(posedge clk);
      model_step(r, xv);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b1111; x0 = 4'h1; x1 = 4'h2; x2 = 4'h3; x3 = 4'h4;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({gnt, s, y, y_valid} !== 11'b0) begin
         errors++;
         $display("FAIL reset_hold gnt=%b s=%0d y=%h yv=%b expected all zero", gnt, s, y, y_valid);
      end
      rst_n = 1'b1;
      drive_cycle(4'b1111, 16'h4321);
      checks++;
      if (gnt !== 4'b0001 || gnt !== exp_gnt()) begin
         errors++;
         $display("FAIL reset_first_grant gnt=%b expected 0001", gnt);
      end
      drive_cycle(4'b0000, 16'h0);
   endtask

   task automatic test_single_source();
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(4'b0100, {4'($urandom), 4'hA, 8'($urandom)});
         checks++;
         if (gnt !== 4'b0100 || s !== 2'd2 || (i > 0 && (y !== 4'hA || !y_valid))) begin
            errors++;
            $display("FAIL single_c%0d gnt=%b s=%0d y=%h yv=%b expected 0100/2/A", i, gnt, s, y,
                     y_valid);
         end
      end
      drive_cycle(4'b0000, 16'h0A00);
      checks++;
      if (gnt !== 4'b0 || y !== 4'hA || y_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_tail gnt=%b y=%h yv=%b expected 0000/A/1", gnt, y, y_valid);
      end
      drive_cycle(4'b0000, 16'h0000);
      checks++;
      if (gnt !== 4'b0 || y !== 4'hA || y_valid !== 1'b0 || s !== 2'd2) begin
         errors++;
         $display("FAIL single_idle gnt=%b y=%h yv=%b s=%0d expected 0000/A/0/2", gnt, y, y_valid, s);
      end
   endtask

   task automatic test_hold_limit();
      logic [3:0] want;
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
         drive_cycle(4'b0011, 16'($urandom));
         want = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0010;
         checks++;
         if (gnt !== want || gnt !== exp_gnt()) begin
            errors++;
            $display("FAIL hold_limit_c%0d gnt=%b expected %b", i, gnt, want);
         end
      end
   endtask

   task automatic test_early_release();
      pulse_reset();
      drive_cycle(4'b0010, 16'h0);
      drive_cycle(4'b1010, 16'h0);
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL early_keep gnt=%b expected 0010", gnt);
      end
      drive_cycle(4'b1000, 16'h0);
      checks++;
      if (gnt !== 4'b1000 || s !== 2'd3) begin
         errors++;
         $display("FAIL early_switch gnt=%b s=%0d expected 1000/3", gnt, s);
      end
   endtask

   task automatic test_lone_owner();
      int bad;
      pulse_reset();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         drive_cycle(4'b0001, 16'($urandom));
         if (gnt !== 4'b0001) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL lone_owner cycles_lost=%0d expected 0", bad);
      end
      // Saturated hold count means a newcomer takes over on its first cycle.
      drive_cycle(4'b0011, 16'h0);
      checks++;
      if (gnt !== 4'b0010 || gnt !== exp_gnt()) begin
         errors++;
         $display("FAIL lone_saturate gnt=%b expected 0010", gnt);
      end
   endtask

   task automatic test_mid_reset();
      pulse_reset();
      drive_cycle(4'b1000, 16'h5000);
      drive_cycle(4'b1000, 16'h5000);
      checks++;
      if (gnt !== 4'b1000 || y !== 4'h5 || y_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre gnt=%b y=%h yv=%b expected 1000/5/1", gnt, y, y_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (gnt !== 4'b0 || y !== 4'h0 || y_valid !== 1'b0 || s !== 2'd0) begin
         errors++;
         $display("FAIL midrst_async gnt=%b y=%h yv=%b s=%0d expected zeros", gnt, y, y_valid, s);
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      drive_cycle(4'b1111, 16'h0);
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL midrst_restart gnt=%b expected 0001", gnt);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) pulse_reset();
         r = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom);
         drive_cycle(r, 16'($urandom));
         checks++;
         if ({gnt, s, y, y_valid} !== {exp_gnt(), 2'(m_s), m_y, m_yv}) begin
            errors++;
            $display("FAIL random_c%0d req=%b got gnt=%b s=%0d y=%h yv=%b expected %b/%0d/%h/%b", i,
                     r, gnt, s, y, y_valid, exp_gnt(), m_s, m_y, m_yv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_hold_limit();
      test_early_release();
      test_lone_owner();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
